mpf_vtp_port_arb: RTL and testbench

- Shares one downstream VTP translation port among N_PORTS upstream requesters.
- Each requester gets a small ingress FIFO. Requests are granted round-robin to the single downstream port.
- Responses are routed back to the originating requester using an in-order tag FIFO. The downstream port returns responses in request order.
- Sits between per-channel AFU-side logic and one VTP service port.

---
 rtl/mpf_vtp_pkg.sv | 15 +
 rtl/mpf_vtp_arb_fifo.sv | 44 ++++
 rtl/mpf_vtp_port_arb.sv | 151 +++++++++++++++
 tb/tb_mpf_vtp_port_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpf_vtp_pkg.sv
// Shared VTP lookup request/response payload types used by the port arbiter
// and the per-channel logic it serves.
package mpf_vtp_pkg;

  typedef struct packed {
    logic [47:0] va;
    logic [7:0]  req_id;
  } t_mpf_vtp_lookup_req;

  typedef struct packed {
    logic [47:0] pa;
    logic        error;
  } t_mpf_vtp_lookup_rsp;

endpackage

// File: rtl/mpf_vtp_arb_fifo.sv
// Small synchronous FIFO with occupancy count. The head entry is visible on
// dout without a pop. Pushes when full and pops when empty are ignored.
module mpf_vtp_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mpf_vtp_port_arb.sv
// Shares one downstream VTP port among N_PORTS requesters: per-port ingress
// FIFOs, round-robin grant, and an in-order tag FIFO to route responses back.
module mpf_vtp_port_arb
  import mpf_vtp_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int REQ_W           = $bits(t_mpf_vtp_lookup_req),
  parameter int RSP_W           = $bits(t_mpf_vtp_lookup_rsp),
  parameter int IN_DEPTH        = 8,
  parameter int AF_SLACK        = 3,
  parameter int MAX_OUTSTANDING = 32
)(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_PORTS-1:0]       up_reqEn,
  input  logic [N_PORTS*REQ_W-1:0] up_req,
  input  logic [N_PORTS-1:0]       up_reqAddrIsVirtual,
  input  logic [N_PORTS-1:0]       up_reqIsOrdered,
  output logic [N_PORTS-1:0]       up_almostFullToAFU,
  output logic [N_PORTS-1:0]       up_rspValid,
  output logic [RSP_W-1:0]         up_rsp,
  input  logic [N_PORTS-1:0]       up_almostFullFromFIU,
  output logic                     dn_reqEn,
  output logic [REQ_W-1:0]         dn_req,
  output logic                     dn_reqAddrIsVirtual,
  output logic                     dn_reqIsOrdered,
  input  logic                     dn_almostFullToAFU,
  input  logic                     dn_rspValid,
  input  logic [RSP_W-1:0]         dn_rsp,
  output logic                     dn_almostFullFromFIU,
  output logic                     err_rsp_no_tag
);
  localparam int IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int ENT_W     = REQ_W + 2;
  localparam int IN_CNT_W  = $clog2(IN_DEPTH) + 1;
  localparam int TAG_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int AF_LEVEL  = IN_DEPTH - AF_SLACK;

  typedef logic [IDX_W-1:0] t_port_idx;

  logic [ENT_W-1:0]    in_dout  [N_PORTS];
  logic [IN_CNT_W-1:0] in_count [N_PORTS];
  logic [N_PORTS-1:0]  in_empty;
  logic [N_PORTS-1:0]  in_full;
  logic [N_PORTS-1:0]  in_pop;

  t_port_idx            rr_ptr;
  t_port_idx            cand;
  logic                 can_issue;
  logic                 gnt_vld_p0;
  t_port_idx            gnt_idx_p0;
  logic [ENT_W-1:0]     gnt_ent_p0;

  t_port_idx            tag_head;
  logic [TAG_CNT_W-1:0] tag_count;
  logic                 tag_empty;
  logic                 tag_full;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in
    mpf_vtp_arb_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (IN_DEPTH)
    ) u_in_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (up_reqEn[gi]),
      .din     ({up_req[gi*REQ_W +: REQ_W], up_reqAddrIsVirtual[gi], up_reqIsOrdered[gi]}),
      .pop     (in_pop[gi]),
      .dout    (in_dout[gi]),
      .count   (in_count[gi])
    );

    assign in_empty[gi] = (in_count[gi] == '0);
    assign in_full[gi]  = (in_count[gi] == IN_CNT_W'(IN_DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(up_reqEn[gi] && in_full[gi]));
    a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      !(up_reqEn[gi] && up_reqAddrIsVirtual[gi] && up_reqIsOrdered[gi]));
  end

  mpf_vtp_arb_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (gnt_vld_p0),
    .din     (gnt_idx_p0),
    .pop     (dn_rspValid),
    .dout    (tag_head),
    .count   (tag_count)
  );

  assign tag_empty = (tag_count == '0);
  assign tag_full  = (tag_count == TAG_CNT_W'(MAX_OUTSTANDING));
  assign can_issue = !dn_almostFullToAFU && !tag_full;

  // Stage p0: round-robin search starting at rr_ptr, pop the winner
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand       = '0;
    in_pop     = '0;
    if (can_issue) begin
      for (int k = 0; k < N_PORTS; k++) begin
        cand = t_port_idx'((int'(rr_ptr) + k) % N_PORTS);
        if (!gnt_vld_p0 && !in_empty[cand]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = cand;
        end
      end
      in_pop[gnt_idx_p0] = gnt_vld_p0;
    end
  end

  assign gnt_ent_p0 = in_dout[gnt_idx_p0];

  // Stage p1: registered downstream request and upstream response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr               <= '0;
      dn_reqEn             <= 1'b0;
      up_rspValid          <= '0;
      err_rsp_no_tag       <= 1'b0;
      up_almostFullToAFU   <= '1;
      dn_almostFullFromFIU <= 1'b1;
    end else begin
      dn_reqEn <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        rr_ptr <= (int'(gnt_idx_p0) == N_PORTS - 1) ? '0 : gnt_idx_p0 + 1'b1;
      end
      if (dn_rspValid && !tag_empty) begin
        up_rspValid <= N_PORTS'(1) << tag_head;
      end else begin
        up_rspValid <= '0;
      end
      if (dn_rspValid && tag_empty) err_rsp_no_tag <= 1'b1;
      for (int i = 0; i < N_PORTS; i++) begin
        up_almostFullToAFU[i] <= (in_count[i] >= IN_CNT_W'(AF_LEVEL));
      end
      dn_almostFullFromFIU <= |up_almostFullFromFIU;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_vld_p0) {dn_req, dn_reqAddrIsVirtual, dn_reqIsOrdered} <= gnt_ent_p0;
    if (dn_rspValid) up_rsp <= dn_rsp;
  end

endmodule

// File: tb/tb_mpf_vtp_port_arb.sv
// Directed bench for the VTP port arbiter: latency, fairness, backpressure,
// tag-FIFO limit, response routing and mid-flight reset.
module tb_mpf_vtp_port_arb;
  import mpf_vtp_pkg::*;

  localparam int N     = 4;
  localparam int REQ_W = $bits(t_mpf_vtp_lookup_req);
  localparam int RSP_W = $bits(t_mpf_vtp_lookup_rsp);

  logic               clk = 1'b0;
  logic               reset_n;
  logic [N-1:0]       up_reqEn;
  logic [N*REQ_W-1:0] up_req;
  logic [N-1:0]       up_reqAddrIsVirtual;
  logic [N-1:0]       up_reqIsOrdered;
  logic [N-1:0]       up_almostFullToAFU;
  logic [N-1:0]       up_rspValid;
  logic [RSP_W-1:0]   up_rsp;
  logic [N-1:0]       up_almostFullFromFIU;
  logic               dn_reqEn;
  logic [REQ_W-1:0]   dn_req;
  logic               dn_reqAddrIsVirtual;
  logic               dn_reqIsOrdered;
  logic               dn_almostFullToAFU;
  logic               dn_rspValid;
  logic [RSP_W-1:0]   dn_rsp;
  logic               dn_almostFullFromFIU;
  logic               err_rsp_no_tag;

  mpf_vtp_port_arb #(.N_PORTS(N)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .up_reqEn             (up_reqEn),
    .up_req               (up_req),
    .up_reqAddrIsVirtual  (up_reqAddrIsVirtual),
    .up_reqIsOrdered      (up_reqIsOrdered),
    .up_almostFullToAFU   (up_almostFullToAFU),
    .up_rspValid          (up_rspValid),
    .up_rsp               (up_rsp),
    .up_almostFullFromFIU (up_almostFullFromFIU),
    .dn_reqEn             (dn_reqEn),
    .dn_req               (dn_req),
    .dn_reqAddrIsVirtual  (dn_reqAddrIsVirtual),
    .dn_reqIsOrdered      (dn_reqIsOrdered),
    .dn_almostFullToAFU   (dn_almostFullToAFU),
    .dn_rspValid          (dn_rspValid),
    .dn_rsp               (dn_rsp),
    .dn_almostFullFromFIU (dn_almostFullFromFIU),
    .err_rsp_no_tag       (err_rsp_no_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [REQ_W-1:0] dn_log[$];
  int               dn_cyc[$];
  logic [N-1:0]     rsp_vld_log[$];
  logic [RSP_W-1:0] rsp_dat_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && dn_reqEn) begin
      dn_log.push_back(dn_req);
      dn_cyc.push_back(cyc);
    end
    if (reset_n && up_rspValid != '0) begin
      rsp_vld_log.push_back(up_rspValid);
      rsp_dat_log.push_back(up_rsp);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input int port, input int seq);
    return REQ_W'(32'h5000_0000 + port * 256 + seq);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    up_reqEn            = '0;
    up_reqAddrIsVirtual = '0;
    up_reqIsOrdered     = '0;
    dn_rspValid         = 1'b0;
  endtask

  task automatic clear_logs();
    dn_log.delete();
    dn_cyc.delete();
    rsp_vld_log.delete();
    rsp_dat_log.delete();
  endtask

  task automatic push1(input int port, input int seq, input logic virt);
    up_reqEn[port]                  = 1'b1;
    up_req[port*REQ_W +: REQ_W]     = mk_req(port, seq);
    up_reqAddrIsVirtual[port]       = virt;
    step(1);
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    dn_almostFullToAFU = 1'b0;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    clear_logs();
  endtask

  initial begin
    reset_n              = 1'b1;
    up_req               = '0;
    up_almostFullFromFIU = '0;
    dn_almostFullToAFU   = 1'b0;
    dn_rsp               = '0;
    clear_inputs();

    // reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_dn_reqEn", 64'(dn_reqEn), 64'd0);
    check("rst_up_rspValid", 64'(up_rspValid), 64'd0);
    check("rst_err", 64'(err_rsp_no_tag), 64'd0);
    check("rst_af", 64'(up_almostFullToAFU), 64'hF);
    @(posedge clk);
    #1;
    step(1);
    reset_n = 1'b1;
    check("rst_af_hold", 64'(up_almostFullToAFU), 64'hF);
    step(1);
    check("rst_af_first_edge", 64'(up_almostFullToAFU), 64'h0);

    // single requester latency and response
    clear_logs();
    push1(2, 1, 1'b1);
    check("t1_grant_cycle", 64'(dn_reqEn), 64'd0);
    step(1);
    check("t1_dn_reqEn", 64'(dn_reqEn), 64'd1);
    check("t1_dn_req", 64'(dn_req), 64'(mk_req(2, 1)));
    check("t1_dn_virt", 64'(dn_reqAddrIsVirtual), 64'd1);
    check("t1_dn_ord", 64'(dn_reqIsOrdered), 64'd0);
    step(1);
    check("t1_dn_single", 64'(dn_reqEn), 64'd0);
    step(3);
    dn_rspValid = 1'b1;
    dn_rsp      = RSP_W'(49'h1_2345_6789_AB);
    step(1);
    dn_rspValid = 1'b0;
    check("t1_rspValid", 64'(up_rspValid), 64'h4);
    check("t1_rsp", 64'(up_rsp), 64'(49'h1_2345_6789_AB));
    step(1);
    check("t1_rspValid_drop", 64'(up_rspValid), 64'h0);
    check("t1_err", 64'(err_rsp_no_tag), 64'd0);

    // fairness
    do_reset();
    for (int s = 0; s < 4; s++) begin
      up_reqEn = '1;
      for (int p = 0; p < N; p++) up_req[p*REQ_W +: REQ_W] = mk_req(p, s);
      step(1);
    end
    clear_inputs();
    step(20);
    check("t2_count", 64'(dn_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < dn_log.size()) check($sformatf("t2_order%0d", i), 64'(dn_log[i]), 64'(mk_req(i % 4, i / 4)));
    end
    if (dn_log.size() == 16) check("t2_back_to_back", 64'(dn_cyc[15] - dn_cyc[0]), 64'd15);

    // downstream backpressure
    do_reset();
    dn_almostFullToAFU = 1'b1;
    for (int s = 0; s < 8; s++) begin
      push1(0, s, 1'b0);
      if (s == 4) check("t3_af_at5", 64'(up_almostFullToAFU[0]), 64'd0);
      if (s == 5) check("t3_af_rise", 64'(up_almostFullToAFU[0]), 64'd1);
    end
    step(2);
    check("t3_blocked", 64'(dn_log.size()), 64'd0);
    dn_almostFullToAFU = 1'b0;
    step(12);
    check("t3_count", 64'(dn_log.size()), 64'd8);
    for (int s = 0; s < 8; s++) begin
      if (s < dn_log.size()) check($sformatf("t3_order%0d", s), 64'(dn_log[s]), 64'(mk_req(0, s)));
    end
    check("t3_af_fall", 64'(up_almostFullToAFU[0]), 64'd0);

    // tag FIFO limit
    do_reset();
    for (int k = 0; k < 40; k++) push1(k % 4, k, 1'b0);
    step(10);
    check("t4_cap", 64'(dn_log.size()), 64'd32);
    if (dn_log.size() >= 32) check("t4_last", 64'(dn_log[31]), 64'(mk_req(3, 31)));
    dn_rspValid = 1'b1;
    dn_rsp      = RSP_W'(49'h0_0000_0000_77);
    step(1);
    dn_rspValid = 1'b0;
    check("t4_rsp_port", 64'(up_rspValid), 64'h1);
    step(5);
    check("t4_one_more", 64'(dn_log.size()), 64'd33);
    if (dn_log.size() >= 33) check("t4_next", 64'(dn_log[32]), 64'(mk_req(0, 32)));
    check("t4_err", 64'(err_rsp_no_tag), 64'd0);

    // response routing
    do_reset();
    push1(3, 0, 1'b0);
    push1(1, 1, 1'b0);
    push1(3, 2, 1'b0);
    push1(0, 3, 1'b0);
    step(3);
    check("t5_issued", 64'(dn_log.size()), 64'd4);
    for (int r = 0; r < 4; r++) begin
      dn_rspValid = 1'b1;
      dn_rsp      = RSP_W'(100 + r);
      step(1);
    end
    dn_rspValid = 1'b0;
    step(2);
    check("t5_rsp_count", 64'(rsp_vld_log.size()), 64'd4);
    if (rsp_vld_log.size() == 4) begin
      check("t5_vld0", 64'(rsp_vld_log[0]), 64'h8);
      check("t5_vld1", 64'(rsp_vld_log[1]), 64'h2);
      check("t5_vld2", 64'(rsp_vld_log[2]), 64'h8);
      check("t5_vld3", 64'(rsp_vld_log[3]), 64'h1);
      for (int r = 0; r < 4; r++) check($sformatf("t5_dat%0d", r), 64'(rsp_dat_log[r]), 64'(100 + r));
    end

    // reset with requests in flight
    do_reset();
    for (int k = 0; k < 5; k++) push1(k % 4, k, 1'b0);
    step(3);
    check("t6_outstanding", 64'(dn_log.size()), 64'd5);
    check("t6_err_before", 64'(err_rsp_no_tag), 64'd0);
    check("t6_af_before", 64'(up_almostFullToAFU), 64'h0);
    #3 reset_n = 1'b0;
    #1;
    check("t6_af_async", 64'(up_almostFullToAFU), 64'hF);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1);
    clear_logs();
    dn_rspValid = 1'b1;
    dn_rsp      = RSP_W'(49'h0_0000_0000_55);
    step(1);
    dn_rspValid = 1'b0;
    check("t6_err", 64'(err_rsp_no_tag), 64'd1);
    check("t6_no_rsp", 64'(up_rspValid), 64'h0);
    step(3);
    check("t6_err_sticky", 64'(err_rsp_no_tag), 64'd1);
    check("t6_no_rsp_log", 64'(rsp_vld_log.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
